bcd_stopwatch_n: RTL and testbench

Parametrised BCD MM:SS stopwatch/timer with a configurable minutes width and an internal tick prescaler (no derived clocks). It has programmable preset slots, up/down counting with terminal stop, saturating minute adjust, a selectable speed multiplier and lap capture. It is the next-generation replacement for the fixed 4-digit stopwatch and sits between the board button/debounce logic and the 7-segment display driver.

---
 rtl/bcd_stopwatch_n_pkg.sv | 36 +++
 rtl/bcd_stopwatch_n_digit.sv | 56 +++++
 rtl/bcd_stopwatch_n.sv | 176 +++++++++++++++++
 tb/tb_bcd_stopwatch_n.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_stopwatch_n_pkg.sv
// Shared constants, direction type and BCD time-word validation for the
// BCD MM:SS stopwatch.
package stopwatch_pkg;

    localparam int unsigned SPEED_MAX     = 3;
    localparam int unsigned SEC_UNITS_MAX = 9;
    localparam int unsigned SEC_TENS_MAX  = 5;
    localparam int unsigned MIN_DIGIT_MAX = 9;

    // Widest time word bcd_valid can inspect (16 digits).
    localparam int unsigned BCD_W_MAX = 64;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // True when every digit of a {minutes, sec tens, sec units} word is in range.
    function automatic logic bcd_valid(input logic [BCD_W_MAX-1:0] w,
                                       input int unsigned min_digits);
        logic        ok;
        logic [3:0]  d;
        int unsigned lim;
        ok = 1'b1;
        for (int unsigned i = 0; i < BCD_W_MAX / 4; i++) begin
            if (i < min_digits + 2) begin
                d   = 4'(w >> (4 * i));
                lim = (i == 0) ? SEC_UNITS_MAX :
                      (i == 1) ? SEC_TENS_MAX  : MIN_DIGIT_MAX;
                if ({28'd0, d} > lim) ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_stopwatch_n_digit.sv
// One BCD digit of the stopwatch ripple chain: counts 0..MAXV up or down,
// wraps with a carry/borrow out, and can be loaded directly.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAXV = 9
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  dir_t       i_dir,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    output logic [3:0] o_digit,
    output logic [3:0] o_digit_nxt,
    output logic       o_co
);

    localparam logic [3:0] MAXD = 4'(MAXV);

    logic [3:0] r_digit;

    // Next digit value: load wins over stepping; carry only on a wrap.
    always_comb begin
        o_digit_nxt = r_digit;
        o_co        = 1'b0;
        if (i_load) begin
            o_digit_nxt = i_load_val;
        end else if (i_en) begin
            if (i_dir == DIR_UP) begin
                if (r_digit == MAXD) begin
                    o_digit_nxt = '0;
                    o_co        = 1'b1;
                end else begin
                    o_digit_nxt = r_digit + 4'd1;
                end
            end else begin
                if (r_digit == '0) begin
                    o_digit_nxt = MAXD;
                    o_co        = 1'b1;
                end else begin
                    o_digit_nxt = r_digit - 4'd1;
                end
            end
        end
    end

    // Digit register with synchronous clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_digit <= '0;
        else       r_digit <= o_digit_nxt;
    end

    assign o_digit = r_digit;

endmodule

// File: rtl/bcd_stopwatch_n.sv
// Parametrised BCD MM:SS stopwatch/timer: prescaled ticks with a speed
// multiplier, up/down counting with terminal stop, preset slots, saturating
// minute adjust and lap capture. All outputs are registered.
module bcd_stopwatch_n
    import stopwatch_pkg::*;
#(
    parameter  int unsigned MIN_DIGITS  = 2,
    parameter  int unsigned NUM_PRESETS = 4,
    parameter  int unsigned TICK_DIV    = 50_000_000,
    localparam int unsigned TW          = 4 * (MIN_DIGITS + 2),
    localparam int unsigned PSEL_W      = ($clog2(NUM_PRESETS) > 1) ? $clog2(NUM_PRESETS) : 1
) (
    input  logic              clk_in,
    input  logic              RESET,
    input  logic              START,
    input  logic              REVERSE,
    input  logic              LOAD,
    input  logic              PRESET_WE,
    input  logic [PSEL_W-1:0] PRESET_SEL,
    input  logic [TW-1:0]     PRESET_DATA,
    input  logic              ADD,
    input  logic              SUBTRACT,
    input  logic              SPEED_UP,
    input  logic              SPEED_DOWN,
    input  logic              LAP,
    output logic [TW-1:0]     Q,
    output logic [TW-1:0]     LAP_Q,
    output logic [1:0]        SPEED,
    output logic              RUNNING,
    output logic              DONE,
    output logic              PRESET_ERR
);

    localparam int unsigned ND = MIN_DIGITS + 2;
    localparam int unsigned MW = 4 * MIN_DIGITS;
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [3:0]  D_MIN_MAX = 4'(MIN_DIGIT_MAX);
    localparam logic [1:0]  SPD_TOP   = 2'(SPEED_MAX);

    logic [TW-1:0] r_presets [NUM_PRESETS];
    logic [TW-1:0] r_lap;
    logic [1:0]    r_speed;
    logic [PW-1:0] r_presc;
    logic          r_running;
    logic          r_done;
    logic          r_perr;

    logic [TW-1:0] w_q, w_q_nxt, w_max, w_term, w_preset, w_load_val;
    logic [ND-1:0] w_dload;
    logic [MW-1:0] w_inc, w_dec, w_min_adj;
    logic [PW-1:0] w_lim;
    logic          w_at_term, w_run, w_tick, w_adj, w_step;
    logic          w_spd_up, w_spd_dn, w_sel_ok, w_wr_ok;
    logic          w_min_full, w_min_zero;
    dir_t          w_dir;

    assign w_dir     = REVERSE ? DIR_DOWN : DIR_UP;
    assign w_term    = REVERSE ? '0 : w_max;
    assign w_at_term = (w_q == w_term);
    assign w_run     = START & ~w_at_term;

    assign w_lim  = PW'((TICK_DIV >> r_speed) - 1);
    assign w_tick = w_run & (r_presc == w_lim);
    assign w_adj  = ADD ^ SUBTRACT;
    // A tick is dropped whenever LOAD or a minute adjust owns this cycle.
    assign w_step = w_tick & ~LOAD & ~w_adj;

    assign w_spd_up = SPEED_UP & ~SPEED_DOWN & (r_speed != SPD_TOP);
    assign w_spd_dn = SPEED_DOWN & ~SPEED_UP & (r_speed != 2'd0);

    assign w_sel_ok = ({{(32-PSEL_W){1'b0}}, PRESET_SEL} < NUM_PRESETS);
    assign w_preset = w_sel_ok ? r_presets[PRESET_SEL] : '0;
    assign w_wr_ok  = bcd_valid(64'(PRESET_DATA), MIN_DIGITS);

    // Minute field +1/-1 as independent BCD ripples; the ripple out of the
    // top digit doubles as the all-9s / all-0s saturation flag.
    for (genvar m = 0; m < MIN_DIGITS; m++) begin : g_min
        logic [3:0] w_d;
        logic       w_ic, w_dc, w_ico, w_dco;
        assign w_d = w_q[8 + 4*m +: 4];
        if (m == 0) begin : g_first
            assign w_ic = 1'b1;
            assign w_dc = 1'b1;
        end else begin : g_next
            assign w_ic = g_min[m-1].w_ico;
            assign w_dc = g_min[m-1].w_dco;
        end
        assign w_ico = w_ic & (w_d == D_MIN_MAX);
        assign w_dco = w_dc & (w_d == 4'd0);
        assign w_inc[4*m +: 4] = ~w_ic ? w_d : ((w_d == D_MIN_MAX) ? 4'd0 : w_d + 4'd1);
        assign w_dec[4*m +: 4] = ~w_dc ? w_d : ((w_d == 4'd0) ? D_MIN_MAX : w_d - 4'd1);
    end

    assign w_min_full = g_min[MIN_DIGITS-1].w_ico;
    assign w_min_zero = g_min[MIN_DIGITS-1].w_dco;
    assign w_min_adj  = (ADD & ~SUBTRACT & ~w_min_full) ? w_inc :
                        (SUBTRACT & ~ADD & ~w_min_zero) ? w_dec : w_q[TW-1:8];

    // Digit chain: seconds load only on LOAD, minutes also on an adjust.
    for (genvar g = 0; g < ND; g++) begin : g_dig
        localparam int unsigned DMAX = (g == 0) ? SEC_UNITS_MAX :
                                       (g == 1) ? SEC_TENS_MAX  : MIN_DIGIT_MAX;
        logic w_en, w_co;

        assign w_max[4*g +: 4] = 4'(DMAX);

        if (g == 0) begin : g_lsd
            assign w_en = w_step;
        end else begin : g_rip
            assign w_en = g_dig[g-1].w_co;
        end

        if (g < 2) begin : g_sec
            assign w_dload[g]          = LOAD;
            assign w_load_val[4*g +: 4] = w_preset[4*g +: 4];
        end else begin : g_mn
            assign w_dload[g]          = LOAD | w_adj;
            assign w_load_val[4*g +: 4] = LOAD ? w_preset[4*g +: 4] : w_min_adj[4*(g-2) +: 4];
        end

        bcd_digit_counter #(.MAXV(DMAX)) u_digit (
            .i_clk       (clk_in),
            .i_rst       (RESET),
            .i_en        (w_en),
            .i_dir       (w_dir),
            .i_load      (w_dload[g]),
            .i_load_val  (w_load_val[4*g +: 4]),
            .o_digit     (w_q[4*g +: 4]),
            .o_digit_nxt (w_q_nxt[4*g +: 4]),
            .o_co        (w_co)
        );
    end

    // Preset slots: only in-range BCD words are stored.
    always_ff @(posedge clk_in) begin
        if (RESET)                                  r_presets <= '{default: '0};
        else if (PRESET_WE & w_wr_ok & w_sel_ok)    r_presets[PRESET_SEL] <= PRESET_DATA;
    end

    // Speed level with saturation at both ends.
    always_ff @(posedge clk_in) begin
        if (RESET)         r_speed <= '0;
        else if (w_spd_up) r_speed <= r_speed + 2'd1;
        else if (w_spd_dn) r_speed <= r_speed - 2'd1;
    end

    // Prescaler: restarts on LOAD or speed change, frozen while not running.
    always_ff @(posedge clk_in) begin
        if (RESET)                            r_presc <= '0;
        else if (LOAD | w_spd_up | w_spd_dn)  r_presc <= '0;
        else if (w_run)                       r_presc <= w_tick ? '0 : r_presc + PW'(1);
    end

    // Registered status: lap capture, terminal pulse, preset error, run state.
    always_ff @(posedge clk_in) begin
        if (RESET) begin
            r_lap     <= '0;
            r_done    <= 1'b0;
            r_perr    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            if (LAP) r_lap <= w_q;
            r_done    <= w_step & (w_q_nxt == w_term);
            r_perr    <= PRESET_WE & ~w_wr_ok;
            r_running <= START & (w_q_nxt != w_term);
        end
    end

    assign Q          = w_q;
    assign LAP_Q      = r_lap;
    assign SPEED      = r_speed;
    assign RUNNING    = r_running;
    assign DONE       = r_done;
    assign PRESET_ERR = r_perr;

endmodule

// File: tb/tb_bcd_stopwatch_n.sv
// Scoreboard bench for bcd_stopwatch_n (TICK_DIV=8, MIN_DIGITS=2).
// Stimulus pushes hand-computed expectations; the negedge monitor pops them.
module tb_bcd_stopwatch_n;

    localparam int K_Q = 0, K_LAPQ = 1, K_SPEED = 2, K_RUN = 3, K_DONE = 4,
                   K_PERR = 5, K_DONECNT = 6, K_PERRCNT = 7;

    typedef struct {
        int          kind;
        logic [15:0] exp;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        RESET = 1'b1, START = 1'b0, REVERSE = 1'b0, LOAD = 1'b0;
    logic        PRESET_WE = 1'b0, ADD = 1'b0, SUBTRACT = 1'b0;
    logic        SPEED_UP = 1'b0, SPEED_DOWN = 1'b0, LAP = 1'b0;
    logic [1:0]  PRESET_SEL = '0;
    logic [15:0] PRESET_DATA = '0;
    logic [15:0] Q, LAP_Q;
    logic [1:0]  SPEED;
    logic        RUNNING, DONE, PRESET_ERR;

    exp_t        sb[$];
    exp_t        e;
    logic [15:0] act;
    int          n_cmp = 0, n_bad = 0, n_chk = 0;
    int          done_cnt = 0, perr_cnt = 0;

    bcd_stopwatch_n #(.MIN_DIGITS(2), .NUM_PRESETS(4), .TICK_DIV(8)) dut (
        .clk_in(clk_in), .RESET(RESET), .START(START), .REVERSE(REVERSE),
        .LOAD(LOAD), .PRESET_WE(PRESET_WE), .PRESET_SEL(PRESET_SEL),
        .PRESET_DATA(PRESET_DATA), .ADD(ADD), .SUBTRACT(SUBTRACT),
        .SPEED_UP(SPEED_UP), .SPEED_DOWN(SPEED_DOWN), .LAP(LAP),
        .Q(Q), .LAP_Q(LAP_Q), .SPEED(SPEED), .RUNNING(RUNNING),
        .DONE(DONE), .PRESET_ERR(PRESET_ERR)
    );

    always #5 clk_in = ~clk_in;

    // Pulse counters sample the registered outputs of the previous cycle.
    always @(posedge clk_in) begin
        if (DONE === 1'b1)       done_cnt++;
        if (PRESET_ERR === 1'b1) perr_cnt++;
    end

    function automatic string kname(input int k);
        case (k)
            K_Q:       return "Q";
            K_LAPQ:    return "LAP_Q";
            K_SPEED:   return "SPEED";
            K_RUN:     return "RUNNING";
            K_DONE:    return "DONE";
            K_PERR:    return "PRESET_ERR";
            K_DONECNT: return "DONE_pulses";
            default:   return "PRESET_ERR_pulses";
        endcase
    endfunction

    function automatic logic [15:0] actual(input int k);
        case (k)
            K_Q:       return Q;
            K_LAPQ:    return LAP_Q;
            K_SPEED:   return {14'd0, SPEED};
            K_RUN:     return {15'd0, RUNNING};
            K_DONE:    return {15'd0, DONE};
            K_PERR:    return {15'd0, PRESET_ERR};
            K_DONECNT: return 16'(done_cnt);
            default:   return 16'(perr_cnt);
        endcase
    endfunction

    // Monitor: compare every pending expectation half a cycle after it is queued.
    always @(negedge clk_in) begin
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = actual(e.kind);
            n_cmp++;
            n_chk++;
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL chk%0d %s: got %h, want %h", n_chk, kname(e.kind), act, e.exp);
            end
        end
    end

    task automatic chk(input int kind, input logic [15:0] exp);
        sb.push_back('{kind, exp});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic write_preset(input logic [1:0] sel, input logic [15:0] d);
        PRESET_SEL = sel; PRESET_DATA = d; PRESET_WE = 1'b1;
        cyc(1);
        PRESET_WE = 1'b0;
    endtask

    task automatic load_slot(input logic [1:0] sel);
        PRESET_SEL = sel; LOAD = 1'b1;
        cyc(1);
        LOAD = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc(2);
        chk(K_Q, 16'h0000); chk(K_LAPQ, 16'h0000); chk(K_SPEED, 16'd0);
        chk(K_RUN, 16'd0);  chk(K_DONE, 16'd0);    chk(K_PERR, 16'd0);
        RESET = 1'b0;

        // 61 seconds counting up
        START = 1'b1; REVERSE = 1'b0;
        cyc(61 * 8);
        chk(K_Q, 16'h0101); chk(K_RUN, 16'd1); chk(K_DONECNT, 16'd0);
        START = 1'b0;
        cyc(1);

        // Count down to terminal 0, hold, then resume upward
        write_preset(2'd1, 16'h0002);
        load_slot(2'd1);
        chk(K_Q, 16'h0002);
        REVERSE = 1'b1; START = 1'b1;
        cyc(16);
        chk(K_Q, 16'h0000); chk(K_DONE, 16'd1);
        cyc(2);
        chk(K_Q, 16'h0000); chk(K_DONE, 16'd0); chk(K_RUN, 16'd0); chk(K_DONECNT, 16'd1);
        REVERSE = 1'b0;
        cyc(7);
        chk(K_Q, 16'h0000);
        cyc(1);
        chk(K_Q, 16'h0001);
        START = 1'b0;

        // Minute ripple up and down, then terminal MAX
        write_preset(2'd0, 16'h0959);
        load_slot(2'd0);
        START = 1'b1;
        cyc(8);
        chk(K_Q, 16'h1000);
        REVERSE = 1'b1;
        cyc(8);
        chk(K_Q, 16'h0959);
        START = 1'b0;
        write_preset(2'd2, 16'h9958);
        load_slot(2'd2);
        REVERSE = 1'b0; START = 1'b1;
        cyc(8);
        chk(K_Q, 16'h9959); chk(K_DONE, 16'd1);
        cyc(16);
        chk(K_Q, 16'h9959); chk(K_RUN, 16'd0); chk(K_DONECNT, 16'd2);
        START = 1'b0;

        // Minute adjust
        write_preset(2'd3, 16'h9930); load_slot(2'd3);
        ADD = 1'b1; cyc(1); ADD = 1'b0;
        chk(K_Q, 16'h9930);
        write_preset(2'd3, 16'h0045); load_slot(2'd3);
        SUBTRACT = 1'b1; cyc(1); SUBTRACT = 1'b0;
        chk(K_Q, 16'h0045);
        write_preset(2'd3, 16'h1045); load_slot(2'd3);
        SUBTRACT = 1'b1; cyc(1); SUBTRACT = 1'b0;
        chk(K_Q, 16'h0945);
        write_preset(2'd3, 16'h0959); load_slot(2'd3);
        ADD = 1'b1; cyc(1); ADD = 1'b0;
        chk(K_Q, 16'h1059);
        write_preset(2'd3, 16'h0530); load_slot(2'd3);
        ADD = 1'b1; cyc(1); ADD = 1'b0;
        chk(K_Q, 16'h0630);
        ADD = 1'b1; SUBTRACT = 1'b1; cyc(1); ADD = 1'b0; SUBTRACT = 1'b0;
        chk(K_Q, 16'h0630);
        PRESET_SEL = 2'd3; LOAD = 1'b1; ADD = 1'b1; cyc(1); LOAD = 1'b0; ADD = 1'b0;
        chk(K_Q, 16'h0530);

        // Speed levels and lap capture
        write_preset(2'd3, 16'h0000); load_slot(2'd3);
        SPEED_UP = 1'b1; cyc(4); SPEED_UP = 1'b0;
        chk(K_SPEED, 16'd3);
        START = 1'b1;
        cyc(5);
        chk(K_Q, 16'h0005);
        START = 1'b0;
        SPEED_DOWN = 1'b1; cyc(4); SPEED_DOWN = 1'b0;
        chk(K_SPEED, 16'd0);
        START = 1'b1;
        cyc(7);
        chk(K_Q, 16'h0005);
        cyc(1);
        chk(K_Q, 16'h0006);
        cyc(48);
        chk(K_Q, 16'h0012);
        LAP = 1'b1; cyc(1); LAP = 1'b0;
        chk(K_LAPQ, 16'h0012); chk(K_Q, 16'h0012);
        cyc(7);
        chk(K_Q, 16'h0013); chk(K_LAPQ, 16'h0012);
        cyc(7);
        LAP = 1'b1; cyc(1); LAP = 1'b0;
        chk(K_Q, 16'h0014); chk(K_LAPQ, 16'h0013);
        START = 1'b0;
        SPEED_UP = 1'b1; SPEED_DOWN = 1'b1; cyc(1); SPEED_UP = 1'b0; SPEED_DOWN = 1'b0;
        chk(K_SPEED, 16'd0);

        // Rejected preset write, write/load collision
        write_preset(2'd1, 16'h0170);
        chk(K_PERR, 16'd1);
        cyc(1);
        chk(K_PERR, 16'd0); chk(K_PERRCNT, 16'd1);
        load_slot(2'd1);
        chk(K_Q, 16'h0002);
        PRESET_SEL = 2'd1; PRESET_DATA = 16'h0333; PRESET_WE = 1'b1; LOAD = 1'b1;
        cyc(1);
        PRESET_WE = 1'b0; LOAD = 1'b0;
        chk(K_Q, 16'h0002);
        load_slot(2'd1);
        chk(K_Q, 16'h0333);

        // Reset while running
        SPEED_UP = 1'b1; cyc(1); SPEED_UP = 1'b0;
        chk(K_SPEED, 16'd1);
        START = 1'b1;
        cyc(5);
        RESET = 1'b1;
        cyc(1);
        chk(K_Q, 16'h0000); chk(K_LAPQ, 16'h0000); chk(K_SPEED, 16'd0); chk(K_DONE, 16'd0);
        RESET = 1'b0; START = 1'b0;
        load_slot(2'd1);
        chk(K_Q, 16'h0000);
        load_slot(2'd2);
        chk(K_Q, 16'h0000);
        cyc(2);
        chk(K_DONECNT, 16'd2); chk(K_PERRCNT, 16'd1);

        // Drain the scoreboard within a bounded window
        cyc(2);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
